// File: rtl/uart_dbg_responder_if.sv
// Byte-stream and memory-port bundle for uart_dbg_responder.
// The responder uses the master modport; the UART FIFOs and interconnect use slave.
interface uart_dbg_responder_if #(
    parameter int AddrWidth = 32
);
    logic [7:0]           rx_data_i;
    logic                 rx_valid_i;
    logic                 rx_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic                 req_o;
    logic                 we_o;
    logic [AddrWidth-1:0] addr_o;
    logic [31:0]          wdata_o;
    logic [3:0]           be_o;
    logic                 gnt_i;
    logic                 rvalid_i;
    logic [31:0]          rdata_i;
    logic                 busy_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, gnt_i, rvalid_i, rdata_i,
        output rx_ready_o, tx_data_o, tx_valid_o, req_o, we_o, addr_o, wdata_o, be_o, busy_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, gnt_i, rvalid_i, rdata_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, req_o, we_o, addr_o, wdata_o, be_o, busy_o
    );
endinterface

// File: rtl/uart_dbg_responder.sv
// UART debug preload responder: decodes WRITE/READ/PING byte commands and issues 32-bit bus transactions.
// Optional feature macro: UART_DBG_WRITE_ACK_EN (completed WRITE answers 0xAC).
module uart_dbg_responder #(
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_dbg_responder_if.master  bus
);
    localparam int TW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TimeoutCycles - 1);
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h03;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MREQ, S_MWAIT, S_RESP} state_t;

    state_t        r_state,    w_state;
    logic          r_we,       w_we;
    logic [1:0]    r_cnt,      w_cnt;
    logic [TW-1:0] r_timer,    w_timer;
    logic [31:0]   r_addr,     w_addr;
    logic [31:0]   r_wdata,    w_wdata;
    logic [23:0]   r_tx_buf,   w_tx_buf;
    logic [1:0]    r_tx_left,  w_tx_left;
    logic [7:0]    r_tx_data,  w_tx_data;
    logic          r_tx_valid, w_tx_valid;
    logic          r_rx_ready, w_rx_ready;
    logic          r_req,      w_req;
    logic          r_busy,     w_busy;
    logic          w_rx_fire, w_tx_fire, w_bus_done;

    // Next-state and next-output decode
    always_comb begin
        w_state    = r_state;
        w_we       = r_we;
        w_cnt      = r_cnt;
        w_timer    = r_timer;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_tx_buf   = r_tx_buf;
        w_tx_left  = r_tx_left;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_req      = r_req;
        w_rx_fire  = bus.rx_valid_i && r_rx_ready;
        w_tx_fire  = r_tx_valid && bus.tx_ready_i;
        w_bus_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_cnt   = 2'd0;
                    w_timer = '0;
                    case (bus.rx_data_i)
                        OP_WRITE: begin
                            w_state = S_ADDR;
                            w_we    = 1'b1;
                        end
                        OP_READ: begin
                            w_state = S_ADDR;
                            w_we    = 1'b0;
                        end
                        OP_PING: begin
                            w_state    = S_RESP;
                            w_tx_data  = 8'h5A;
                            w_tx_valid = 1'b1;
                            w_tx_left  = 2'd0;
                        end
                        default: begin
                            w_state    = S_RESP;
                            w_tx_data  = 8'hEE;
                            w_tx_valid = 1'b1;
                            w_tx_left  = 2'd0;
                        end
                    endcase
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_ADDR, S_DATA: begin
                if (w_rx_fire) begin
                    w_timer = '0;
                    w_cnt   = r_cnt + 2'd1;
                    // Low address bits are cleared on every shift; only the final shift lands byte 0 there.
                    if (r_state == S_ADDR) begin
                        w_addr = {bus.rx_data_i, r_addr[31:8]} & 32'hFFFF_FFFC;
                    end else begin
                        w_wdata = {bus.rx_data_i, r_wdata[31:8]};
                    end
                    if (r_cnt == 2'd3) begin
                        if ((r_state == S_ADDR) && r_we) begin
                            w_state = S_DATA;
                        end else begin
                            w_state = S_MREQ;
                            w_req   = 1'b1;
                        end
                    end else begin
                        w_state = r_state;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_MREQ: begin
                if (bus.gnt_i) begin
                    w_req      = 1'b0;
                    w_state    = S_MWAIT;
                    w_bus_done = bus.rvalid_i;
                end else begin
                    w_req = 1'b1;
                end
            end
            S_MWAIT: begin
                w_bus_done = bus.rvalid_i;
            end
            S_RESP: begin
                if (w_tx_fire) begin
                    if (r_tx_left == 2'd0) begin
                        w_tx_valid = 1'b0;
                        w_state    = S_IDLE;
                    end else begin
                        w_tx_data = r_tx_buf[7:0];
                        w_tx_buf  = {8'h00, r_tx_buf[23:8]};
                        w_tx_left = r_tx_left - 2'd1;
                    end
                end else begin
                    w_tx_valid = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_bus_done) begin
            if (r_we) begin
`ifdef UART_DBG_WRITE_ACK_EN
                w_state    = S_RESP;
                w_tx_data  = 8'hAC;
                w_tx_valid = 1'b1;
                w_tx_left  = 2'd0;
`else
                w_state = S_IDLE;
`endif
            end else begin
                w_state    = S_RESP;
                w_tx_data  = bus.rdata_i[7:0];
                w_tx_buf   = bus.rdata_i[31:8];
                w_tx_left  = 2'd3;
                w_tx_valid = 1'b1;
            end
        end else begin
            w_tx_left = w_tx_left;
        end

        w_rx_ready = (w_state == S_IDLE) || (w_state == S_ADDR) || (w_state == S_DATA);
        w_busy     = (w_state != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_cnt      <= 2'd0;
            r_timer    <= '0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_tx_buf   <= 24'h00_0000;
            r_tx_left  <= 2'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_we       <= w_we;
            r_cnt      <= w_cnt;
            r_timer    <= w_timer;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_tx_buf   <= w_tx_buf;
            r_tx_left  <= w_tx_left;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_rx_ready <= w_rx_ready;
            r_req      <= w_req;
            r_busy     <= w_busy;
        end
    end

    assign bus.rx_ready_o = r_rx_ready;
    assign bus.tx_data_o  = r_tx_data;
    assign bus.tx_valid_o = r_tx_valid;
    assign bus.req_o      = r_req;
    assign bus.we_o       = r_we;
    assign bus.addr_o     = r_addr[AddrWidth-1:0];
    assign bus.wdata_o    = r_wdata;
    assign bus.be_o       = 4'hF;
    assign bus.busy_o     = r_busy;
endmodule

// File: tb/tb_uart_dbg_responder.sv
// Directed bench for uart_dbg_responder: command table plus hand-written timing sequences.
module tb_uart_dbg_responder;
    localparam int TO = 16;
`ifdef UART_DBG_WRITE_ACK_EN
    localparam int WACK = 1;
`else
    localparam int WACK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_dbg_responder_if #(.AddrWidth(32)) bus ();

    uart_dbg_responder #(.AddrWidth(32), .TimeoutCycles(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    typedef struct {
        logic [71:0] cmd;
        int          len;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        int          exp_nreq;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_ntx;
        logic [31:0] exp_tx;
    } vec_t;

    vec_t vecs [6];

    int total = 0;
    int bad   = 0;
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    int gnt_delay = 0, rv_delay = 1, gnt_wait = 0, rv_cnt = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic tx_hold = 1'b0;
    int n_req = 0, req_cycles = 0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    logic last_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge and log handshakes that the next rising edge completes.
    task automatic step();
        @(negedge clk);
        bus.rvalid_i = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) bus.rvalid_i = 1'b1;
        end
        bus.gnt_i = 1'b0;
        if (bus.req_o) begin
            if (gnt_wait >= gnt_delay) begin
                bus.gnt_i = 1'b1;
                gnt_wait  = 0;
                if (rv_delay == 0) bus.rvalid_i = 1'b1;
                else rv_cnt = rv_delay;
            end else begin
                gnt_wait++;
            end
        end else begin
            gnt_wait = 0;
        end
        bus.rdata_i    = rdata_cfg;
        bus.rx_valid_i = (rx_q.size() != 0);
        bus.rx_data_i  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        if (bus.rx_valid_i && bus.rx_ready_o) void'(rx_q.pop_front());
        bus.tx_ready_i = !tx_hold;
        if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_data_o);
        if (bus.req_o) req_cycles++;
        if (bus.req_o && bus.gnt_i) begin
            n_req++;
            last_addr  = bus.addr_o;
            last_we    = bus.we_o;
            last_wdata = bus.wdata_o;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (rx_q.size() != 0 && n < 200) begin step(); n++; end
        step();
        while (bus.busy_o && n < 400) begin step(); n++; end
        chk({name, "_done"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    task automatic push(input logic [71:0] cmd, input int len);
        logic [71:0] c;
        c = cmd;
        for (int j = 0; j < len; j++) rx_q.push_back(c[8*j +: 8]);
    endtask

    initial begin
        int n0, n, hold_bad, rdy_bad, tv;
        vecs[0] = '{72'hDE_AD_BE_EF_80_00_10_00_01, 9, 0, 0, 32'h0, 1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, WACK, 32'h0000_00AC};
        vecs[1] = '{72'h00_00_00_00_80_00_00_04_02, 5, 0, 1, 32'h1234_5678, 1, 1'b0, 32'h8000_0004, 32'h0, 4, 32'h1234_5678};
        vecs[2] = '{72'h00_00_00_00_00_00_00_00_7F, 1, 0, 1, 32'h0, 0, 1'b0, 32'h0, 32'h0, 1, 32'h0000_00EE};
        vecs[3] = '{72'h00_00_00_00_00_00_00_00_03, 1, 0, 1, 32'h0, 0, 1'b0, 32'h0, 32'h0, 1, 32'h0000_005A};
        vecs[4] = '{72'h00_00_00_00_11_22_33_07_02, 5, 0, 0, 32'hA5C3_0F81, 1, 1'b0, 32'h1122_3304, 32'h0, 4, 32'hA5C3_0F81};
        vecs[5] = '{72'h11_22_33_44_00_00_00_0B_01, 9, 2, 1, 32'h0, 1, 1'b1, 32'h0000_0008, 32'h1122_3344, WACK, 32'h0000_00AC};

        bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.tx_ready_i = 1'b1;
        bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = 32'h0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_rx_ready", {31'd0, bus.rx_ready_o}, 32'd0);
        chk("rst_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
        chk("rst_tx_data",  {24'd0, bus.tx_data_o}, 32'd0);
        chk("rst_req",      {31'd0, bus.req_o}, 32'd0);
        chk("rst_we",       {31'd0, bus.we_o}, 32'd0);
        chk("rst_addr",     bus.addr_o, 32'd0);
        chk("rst_wdata",    bus.wdata_o, 32'd0);
        chk("rst_be",       {28'd0, bus.be_o}, 32'h0000_000F);
        chk("rst_busy",     {31'd0, bus.busy_o}, 32'd0);
        rst = 1'b0;
        step();
        chk("rx_ready_after_rst", {31'd0, bus.rx_ready_o}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            gnt_delay = vecs[i].gd; rv_delay = vecs[i].rd; rdata_cfg = vecs[i].rdata;
            tx_q.delete();
            n0 = n_req;
            push(vecs[i].cmd, vecs[i].len);
            wait_done($sformatf("v%0d", i));
            chk($sformatf("v%0d_nreq", i), n_req - n0, vecs[i].exp_nreq);
            chk($sformatf("v%0d_ntx", i), tx_q.size(), vecs[i].exp_ntx);
            for (int j = 0; j < vecs[i].exp_ntx && j < tx_q.size(); j++)
                chk($sformatf("v%0d_tx%0d", i, j), {24'd0, tx_q[j]}, {24'd0, vecs[i].exp_tx[8*j +: 8]});
            if (vecs[i].exp_nreq != 0) begin
                chk($sformatf("v%0d_addr", i), last_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_we", i), {31'd0, last_we}, {31'd0, vecs[i].exp_we});
                if (vecs[i].exp_we) chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
            end
        end

        // Delayed grant and response: req_o high for exactly four cycles.
        gnt_delay = 3; rv_delay = 2; rdata_cfg = 32'h1234_5678;
        tx_q.delete(); req_cycles = 0;
        push(72'h80_00_00_04_02, 5);
        wait_done("slow_rd");
        chk("slow_rd_req_cycles", req_cycles, 32'd4);
        chk("slow_rd_ntx", tx_q.size(), 32'd4);
        if (tx_q.size() == 4) chk("slow_rd_bytes", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h1234_5678);

        // Inter-byte timeout after a partial READ.
        gnt_delay = 0; rv_delay = 1; tx_q.delete(); n0 = n_req;
        push(72'h00_00_02, 3);
        n = 0;
        while (rx_q.size() != 0 && n < 50) begin step(); n++; end
        repeat (16) step();
        chk("to_busy_before", {31'd0, bus.busy_o}, 32'd1);
        step();
        chk("to_busy_after", {31'd0, bus.busy_o}, 32'd0);
        chk("to_rx_ready", {31'd0, bus.rx_ready_o}, 32'd1);
        chk("to_nreq", n_req - n0, 32'd0);
        chk("to_ntx", tx_q.size(), 32'd0);
        push(72'h03, 1);
        wait_done("to_ping");
        chk("to_ping_ntx", tx_q.size(), 32'd1);
        if (tx_q.size() == 1) chk("to_ping_byte", {24'd0, tx_q[0]}, 32'h5A);

        // TX back-pressure, with a PING queued behind the READ response.
        rdata_cfg = 32'h1234_5678; tx_hold = 1'b1; tx_q.delete();
        push(72'h00_00_00_00_02, 5);
        n = 0;
        while (!bus.tx_valid_o && n < 50) begin step(); n++; end
        chk("bp_tx_valid_seen", {31'd0, bus.tx_valid_o}, 32'd1);
        push(72'h03, 1);
        hold_bad = 0; rdy_bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!bus.tx_valid_o || bus.tx_data_o !== 8'h78) hold_bad++;
            if (bus.rx_ready_o) rdy_bad++;
        end
        chk("bp_hold_stable", hold_bad, 32'd0);
        chk("bp_ping_pending", rx_q.size(), 32'd1);
        tx_hold = 1'b0;
        n = 0;
        while ((tx_q.size() < 5 || bus.busy_o) && n < 100) begin
            step(); n++;
            if (tx_q.size() < 4 && bus.rx_ready_o) rdy_bad++;
        end
        chk("bp_rx_ready_low", rdy_bad, 32'd0);
        chk("bp_ntx", tx_q.size(), 32'd5);
        if (tx_q.size() == 5) begin
            chk("bp_bytes", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h1234_5678);
            chk("bp_ping", {24'd0, tx_q[4]}, 32'h5A);
        end

        // Reset while a request is pending; a late response must be ignored.
        gnt_delay = 20; tx_q.delete();
        push(72'h00_00_00_00_02, 5);
        n = 0;
        while (!bus.req_o && n < 50) begin step(); n++; end
        step(); step();
        chk("mr_req_high", {31'd0, bus.req_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("mr_req_low", {31'd0, bus.req_o}, 32'd0);
        chk("mr_busy_low", {31'd0, bus.busy_o}, 32'd0);
        rst = 1'b0;
        n0 = n_req; rv_cnt = 2; tv = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.tx_valid_o) tv++;
        end
        chk("mr_no_tx_valid", tv, 32'd0);
        chk("mr_ntx", tx_q.size(), 32'd0);
        chk("mr_nreq", n_req - n0, 32'd0);
        gnt_delay = 0;
        push(72'h03, 1);
        wait_done("mr_ping");
        chk("mr_ping_ntx", tx_q.size(), 32'd1);
        if (tx_q.size() == 1) chk("mr_ping_byte", {24'd0, tx_q[0]}, 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
